bbox_overlay: RTL

Downstream stage of the bounding-box accumulator. It consumes the previous-frame box coordinates (x/y min/max) and the RGB565 video stream with its href/vsync timing. It burns a solid rectangle outline of programmable thickness into the pixels before display. All outputs are registered, giving a fixed 1-cycle pass-through latency. Timing signals are delayed to match.

---
 rtl/bbox_pkg.sv | 40 ++++
 rtl/pixel_coord_counter.sv | 51 +++++
 rtl/bbox_overlay.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/bbox_pkg.sv
// Shared types and constants for the bounding-box pipeline (accumulator and overlay).
package bbox_pkg;

  localparam int unsigned IMG_WIDTH_DEF  = 640;
  localparam int unsigned IMG_HEIGHT_DEF = 480;

  localparam int unsigned COORD_W  = 10;
  localparam int unsigned RGB565_W = 16;

  typedef logic [COORD_W-1:0]  coord_t;
  typedef logic [RGB565_W-1:0] rgb565_t;

  localparam rgb565_t COLOR_RED   = 16'hF800;
  localparam rgb565_t COLOR_GREEN = 16'h07E0;

  // Pattern the accumulator emits for a frame with no detected pixels (min > max).
  localparam coord_t EMPTY_X_MIN = coord_t'(IMG_WIDTH_DEF);
  localparam coord_t EMPTY_X_MAX = '0;
  localparam coord_t EMPTY_Y_MIN = coord_t'(IMG_HEIGHT_DEF);
  localparam coord_t EMPTY_Y_MAX = '0;

  typedef struct packed {
    coord_t x_min;
    coord_t x_max;
    coord_t y_min;
    coord_t y_max;
  } box_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StPass  = 2'd2
  } ov_state_e;

  // A box is usable only when both axes are non-inverted.
  function automatic logic box_valid(input box_t b);
    return (b.x_min <= b.x_max) && (b.y_min <= b.y_max);
  endfunction

endpackage

// File: rtl/pixel_coord_counter.sv
// Raster x/y position of the incoming pixel; both counters clear during vsync.
module pixel_coord_counter
  import bbox_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int unsigned IMG_HEIGHT = IMG_HEIGHT_DEF
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_vsync,
  input  logic   i_href,
  input  logic   i_pix_valid,
  output coord_t o_x,
  output coord_t o_y
);

  coord_t r_x, r_y;
  coord_t w_x_d, w_y_d;

  // Next position: vsync clear has priority over pixel advance.
  always_comb begin
    w_x_d = r_x;
    w_y_d = r_y;
    if (i_vsync) begin
      w_x_d = '0;
      w_y_d = '0;
    end else if (i_href && i_pix_valid) begin
      if (r_x == coord_t'(IMG_WIDTH - 1)) begin
        w_x_d = '0;
        w_y_d = (r_y == coord_t'(IMG_HEIGHT - 1)) ? '0 : r_y + coord_t'(1);
      end else begin
        w_x_d = r_x + coord_t'(1);
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else begin
      r_x <= w_x_d;
      r_y <= w_y_d;
    end
  end

  assign o_x = r_x;
  assign o_y = r_y;

endmodule

// File: rtl/bbox_overlay.sv
// Burns the previous frame's bounding box outline into the RGB565 stream with a fixed
// 1-cycle latency. Optional crosshair through the box centre: define BBOX_CROSSHAIR_EN.
module bbox_overlay
  import bbox_pkg::*;
#(
  parameter int unsigned IMG_WIDTH   = IMG_WIDTH_DEF,
  parameter int unsigned IMG_HEIGHT  = IMG_HEIGHT_DEF,
  parameter int unsigned LINE_W      = 2,
  parameter logic [15:0] BOX_COLOR   = COLOR_RED,
  parameter logic [15:0] CROSS_COLOR = COLOR_GREEN
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vsync_i,
  input  logic        href_i,
  input  logic        pix_valid_i,
  input  logic [15:0] pix_data_i,
  input  logic [9:0]  x_min_i,
  input  logic [9:0]  x_max_i,
  input  logic [9:0]  y_min_i,
  input  logic [9:0]  y_max_i,
  output logic        vsync_o,
  output logic        href_o,
  output logic        pix_valid_o,
  output logic [15:0] pix_data_o,
  output logic        box_active_o
);

  // Elaboration-time parameter sanity.
  if (LINE_W < 1 || LINE_W > 8) begin : g_bad_line_w
    $error("bbox_overlay: LINE_W must be 1..8");
  end
  if (CROSS_COLOR == BOX_COLOR) begin : g_bad_colors
    $error("bbox_overlay: CROSS_COLOR must differ from BOX_COLOR");
  end

  localparam logic [10:0] LW11 = 11'(LINE_W);

  logic      r_vsync_d, r_href, r_valid;
  logic [15:0] r_pix;
  box_t      r_box;
  ov_state_e r_state, w_state_d;

  coord_t    w_x, w_y;
  box_t      w_box_in;
  logic      w_latch, w_box_ok, w_overlay_en, w_strobe;
  logic      w_inside, w_edge, w_hit;
  logic [10:0] w_x11, w_y11, w_xmin11, w_xmax11, w_ymin11, w_ymax11;
  logic [15:0] w_pix_d;

  pixel_coord_counter #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT)
  ) u_coord (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_vsync     (vsync_i),
    .i_href      (href_i),
    .i_pix_valid (pix_valid_i),
    .o_x         (w_x),
    .o_y         (w_y)
  );

  assign w_box_in = '{x_min: x_min_i, x_max: x_max_i, y_min: y_min_i, y_max: y_max_i};
  assign w_box_ok = box_valid(w_box_in);
  // Upstream settles during vsync; its falling edge marks the start of the new frame.
  assign w_latch  = r_vsync_d && !vsync_i;

  // Shadow box, held for the whole frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_box <= '0;
    end else if (w_latch) begin
      r_box <= w_box_in;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // FSM next state: every state re-decides only at a vsync falling edge.
  always_comb begin
    w_state_d = r_state;
    if (w_latch) begin
      w_state_d = w_box_ok ? StArmed : StPass;
    end
  end

  // FSM outputs.
  always_comb begin
    w_overlay_en = 1'b0;
    unique case (r_state)
      StArmed: w_overlay_en = 1'b1;
      StIdle,
      StPass:  w_overlay_en = 1'b0;
      default: w_overlay_en = 1'b0;
    endcase
  end

  assign box_active_o = w_overlay_en;

  // 11-bit arithmetic so min+LINE_W and x+LINE_W never wrap.
  assign w_x11    = {1'b0, w_x};
  assign w_y11    = {1'b0, w_y};
  assign w_xmin11 = {1'b0, r_box.x_min};
  assign w_xmax11 = {1'b0, r_box.x_max};
  assign w_ymin11 = {1'b0, r_box.y_min};
  assign w_ymax11 = {1'b0, r_box.y_max};

  assign w_inside = (w_x11 >= w_xmin11) && (w_x11 <= w_xmax11) &&
                    (w_y11 >= w_ymin11) && (w_y11 <= w_ymax11);
  // Thin boxes satisfy an edge term everywhere and come out solid.
  assign w_edge   = (w_x11 < w_xmin11 + LW11) || (w_x11 + LW11 > w_xmax11) ||
                    (w_y11 < w_ymin11 + LW11) || (w_y11 + LW11 > w_ymax11);
  assign w_hit    = w_inside && w_edge;
  // vsync wins over href: no overlay while blanking.
  assign w_strobe = href_i && pix_valid_i && !vsync_i;

`ifdef BBOX_CROSSHAIR_EN
  logic [10:0] r_cx, r_cy;
  logic        w_cross;

  // Box centre, taken together with the shadow box.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cx <= '0;
      r_cy <= '0;
    end else if (w_latch) begin
      r_cx <= ({1'b0, x_min_i} + {1'b0, x_max_i}) >> 1;
      r_cy <= ({1'b0, y_min_i} + {1'b0, y_max_i}) >> 1;
    end
  end

  assign w_cross = w_inside && ((w_x11 == r_cx) || (w_y11 == r_cy));

  // Pixel select: border over crosshair over input.
  always_comb begin
    w_pix_d = pix_data_i;
    if (w_overlay_en && w_strobe) begin
      if (w_hit) begin
        w_pix_d = BOX_COLOR;
      end else if (w_cross) begin
        w_pix_d = CROSS_COLOR;
      end
    end
  end
`else
  // Pixel select: border or input.
  always_comb begin
    w_pix_d = pix_data_i;
    if (w_overlay_en && w_strobe && w_hit) begin
      w_pix_d = BOX_COLOR;
    end
  end
`endif

  // Output stage: data and timing share the same single register delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync_d <= 1'b0;
      r_href    <= 1'b0;
      r_valid   <= 1'b0;
      r_pix     <= '0;
    end else begin
      r_vsync_d <= vsync_i;
      r_href    <= href_i;
      r_valid   <= pix_valid_i;
      r_pix     <= w_pix_d;
    end
  end

  assign vsync_o     = r_vsync_d;
  assign href_o      = r_href;
  assign pix_valid_o = r_valid;
  assign pix_data_o  = r_pix;

endmodule
